// File: rtl/operand_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_unit_pkg
// Description : Shared pipeline widths, writeback port type and hit helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_unit_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] c_reg_zero = '0;

    typedef struct packed {
        logic              en;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_port_t;

    function automatic logic wb_hit(input wb_port_t wb, input logic [REG_W-1:0] r);
        return wb.en && (wb.addr == r) && (r != c_reg_zero);
    endfunction

    function automatic logic [NUM_REGS-1:0] wb_mask(input wb_port_t wb);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (wb.en && (wb.addr != c_reg_zero))
            mask[wb.addr] = 1'b1;
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_unit_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : Resolves one source operand from RF data and two writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass
    import operand_fetch_unit_pkg::*;
(
    input  logic [REG_W-1:0]  r,
    input  logic [DATA_W-1:0] rf_data,
    input  wb_port_t          wb1,
    input  wb_port_t          wb2,
    output logic [DATA_W-1:0] operand
);

    // Port 2 has write priority in the RF, so it also wins the bypass.
    always_comb begin
        operand = rf_data;
        if (r == c_reg_zero)
            operand = '0;
        else if (wb_hit(wb2, r))
            operand = wb2.data;
        else if (wb_hit(wb1, r))
            operand = wb1.data;
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_unit
// Description : Issue-side RF reader with writeback bypass, hazard scoreboard
//               and a one-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_W-1:0]       in_rs,
    input  logic [REG_W-1:0]       in_rt,
    input  logic [REG_W-1:0]       in_rd,
    input  logic                   in_wen,
    output logic [REG_W-1:0]       rf_raddr1,
    output logic [REG_W-1:0]       rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic                   wb1_en,
    input  logic [REG_W-1:0]       wb1_addr,
    input  logic [DATA_W-1:0]      wb1_data,
    input  logic                   wb2_en,
    input  logic [REG_W-1:0]       wb2_addr,
    input  logic [DATA_W-1:0]      wb2_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_rs_data,
    output logic [DATA_W-1:0]      out_rt_data,
    output logic [REG_W-1:0]       out_rd,
    output logic                   out_wen,
    output logic [NUM_REGS-1:0]    pending,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    wb_port_t                w_wb1, w_wb2;
    logic [DATA_W-1:0]       w_rs_data, w_rt_data;
    logic [NUM_REGS-1:0]     w_clear, w_set, w_flush_clr, w_pending_nxt;
    logic                    w_raw, w_waw, w_accept;

    logic [NUM_REGS-1:0]     r_pending;
    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_rs_data, r_out_rt_data;
    logic [REG_W-1:0]        r_out_rd;
    logic                    r_out_wen;
    logic [STALL_CNT_W-1:0]  r_stall_cycles;

    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;

    assign w_wb1 = '{en: wb1_en, addr: wb1_addr, data: wb1_data};
    assign w_wb2 = '{en: wb2_en, addr: wb2_addr, data: wb2_data};

    operand_bypass u_bypass_rs (
        .r       (in_rs),
        .rf_data (rf_rdata1),
        .wb1     (w_wb1),
        .wb2     (w_wb2),
        .operand (w_rs_data)
    );

    operand_bypass u_bypass_rt (
        .r       (in_rt),
        .rf_data (rf_rdata2),
        .wb1     (w_wb1),
        .wb2     (w_wb2),
        .operand (w_rt_data)
    );

    // A register being written back this cycle is no longer a hazard.
    assign w_clear = wb_mask(w_wb1) | wb_mask(w_wb2);

    assign w_raw = ((in_rs != c_reg_zero) && r_pending[in_rs] && !w_clear[in_rs]) ||
                   ((in_rt != c_reg_zero) && r_pending[in_rt] && !w_clear[in_rt]);
    assign w_waw = in_wen && (in_rd != c_reg_zero) && r_pending[in_rd] && !w_clear[in_rd];

    assign in_ready = !flush && !w_raw && !w_waw && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_set       = '0;
        w_flush_clr = '0;
        if (w_accept && in_wen && (in_rd != c_reg_zero))
            w_set[in_rd] = 1'b1;
        if (flush && r_out_valid && r_out_wen)
            w_flush_clr[r_out_rd] = 1'b1;
    end

    // Set is applied last so it wins over a same-cycle clear.
    assign w_pending_nxt = ((r_pending & ~w_clear & ~w_flush_clr) | w_set) &
                           ~{{(NUM_REGS-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending      <= '0;
            r_out_valid    <= 1'b0;
            r_out_rs_data  <= '0;
            r_out_rt_data  <= '0;
            r_out_rd       <= '0;
            r_out_wen      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_rs_data <= w_rs_data;
                r_out_rt_data <= w_rt_data;
                r_out_rd      <= in_rd;
                r_out_wen     <= in_wen;
            end else if ((r_out_valid && out_ready) || flush) begin
                r_out_valid   <= 1'b0;
            end
            if (in_valid && !in_ready && (r_stall_cycles != {STALL_CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign pending      = r_pending;
    assign out_valid    = r_out_valid;
    assign out_rs_data  = r_out_rs_data;
    assign out_rt_data  = r_out_rt_data;
    assign out_rd       = r_out_rd;
    assign out_wen      = r_out_wen;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
